acc_rmw_ctrl: RTL and testbench
===============================

// Module: acc_rmw_ctrl
// PURPOSE
//  Read-modify-write front end for the accumulator memory (acc_unit, OUTPUT_REG=1). Takes signed partial
//  sums from the systolic array column outputs, adds each to the stored word at its address (or overwrites
//  on first pass), writes back. Also drains a contiguous address range to a valid/ready output stream.
// PARAMETERS
//  DATA_WIDTH   32  accumulator word width (signed), equals acc_unit DATA_WIDTH
//  PSUM_WIDTH   16  incoming partial-sum width (signed), PSUM_WIDTH <= DATA_WIDTH
//  ADDR_WIDTH   12  accumulator address width, equals acc_unit ADDR_WIDTH
// PORTS
//  clk             in   1           clock, all state updates on posedge
//  reset           in   1           asynchronous, active-low reset
//  in_valid        in   1           partial sum offered
//  in_ready        out  1           partial sum accepted when in_valid & in_ready
//  in_addr         in   ADDR_WIDTH  target accumulator address
//  in_data         in   PSUM_WIDTH  signed partial sum
//  in_first        in   1           1: write sext(in_data), ignore stored value
//  drain_start     in   1           pulse: start drain (honoured only in IDLE with drain_count != 0)
//  drain_base      in   ADDR_WIDTH  first drain address
//  drain_count     in   ADDR_WIDTH+1 number of words to drain
//  drain_clear     in   1           sampled with drain_start: write 0 to each drained address
//  out_valid       out  1           drained word valid
//  out_ready       in   1           consumer accepts drained word
//  out_data        out  DATA_WIDTH  drained word
//  out_last        out  1           marks final drained word
//  busy            out  1           high when not IDLE or pipeline non-empty
//  ovf_sticky      out  1           set on any saturation; cleared by reset or accepted drain_start
//  mem_read_req    out  1           to acc_unit read_req
//  mem_read_addr   out  ADDR_WIDTH  to acc_unit read_addr
//  mem_read_data   in   DATA_WIDTH  from acc_unit, valid 1 cycle after mem_read_req
//  mem_write_req   out  1           to acc_unit write_req
//  mem_write_addr  out  ADDR_WIDTH  to acc_unit write_addr
//  mem_write_data  out  DATA_WIDTH  to acc_unit write_data
// BEHAVIOUR
//  Reset (reset=0): state IDLE, stage-1 and forward regs invalid, all outputs 0 except in_ready=0; memory untouched.
//  FSM: IDLE -> DRAIN_WAIT (drain_start accepted) -> DRAIN_RD -> DRAIN_OUT -> DRAIN_RD | IDLE.
//  in_ready = (state==IDLE) & ~drain_start. drain_start with count 0 or outside IDLE: ignored.
//  Accumulate pipe, one element/cycle: accept cycle T drives mem_read_req=1, mem_read_addr=in_addr
//   combinationally; stage-1 regs capture addr/data/first. Cycle T+1: mem_write_req=1,
//   write_addr=s1_addr, write_data = first ? sext(psum) : sat(old + sext(psum)), all from regs + mem_read_data.
//  old = (fwd_valid & fwd_addr==s1_addr) ? fwd_data : mem_read_data; fwd regs hold the write issued
//   in the previous cycle. Result correct for any back-to-back same-address sequence, independent of
//   memory write edge.
//  sat: sum in DATA_WIDTH+1 bits, clamp to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1]; clamp sets ovf_sticky.
//  DRAIN_WAIT: stays until stage-1 empty (write of last accepted element done), then DRAIN_RD.
//  DRAIN_RD: read addr = (drain_base + idx) mod 2^ADDR_WIDTH; next cycle capture into out_data,
//   out_valid=1, out_last = (idx==drain_count-1); if drain_clear, mem_write 0 to that addr same cycle.
//  DRAIN_OUT: hold out_data/out_last stable while out_valid & ~out_ready; on handshake idx++,
//   -> DRAIN_RD, or -> IDLE after last. Peak drain rate 1 word / 2 cycles.
//  Address wrap: base+idx past 2^ADDR_WIDTH-1 wraps to 0; drain_count = 2^ADDR_WIDTH drains whole memory.
//  Reset mid-operation: in-flight RMW and drain abandoned; no partial write issued after reset asserts.
//  busy = (state!=IDLE) | s1_valid.
// TESTING
//  1 first=1 addr 5 data 7, then first=0 addr 5 data -3 next cycle -> mem[5]=4, exactly 2 writes, no bubble.
//  2 8 back-to-back first=0 writes of +1 to addr 9 (mem[9]=0) -> mem[9]=8 (forwarding), in_ready held 1.
//  3 mem[3]=0x7FFFFFF0, add +0x7FFF -> mem[3]=0x7FFFFFFF, ovf_sticky=1; negative mirror clamps to 0x80000000.
//  4 drain base 0xFFE count 4 clear=1, out_ready toggling -> 0xFFE,0xFFF,0x000,0x001 in order, out_last on 4th,
//    data stable under stall, all four addresses read 0 afterwards, back to IDLE, busy=0.
//  5 drain_start while stage-1 valid -> drain waits for write, first drained word includes it; in_ready=0 in drain.
//  6 reset asserted mid-drain and mid-RMW -> out_valid/mem_write_req drop immediately, FSM IDLE, no further writes.

Source files
------------

// File: rtl/acc_rmw_ctrl_if.sv
// ----------------------------------------------------------------------------
// acc_rmw_ctrl_if
// Bundles every handshake and bus signal of acc_rmw_ctrl: the partial-sum
// input stream, the drain command, the drain output stream, status flags and
// the read/write ports towards the accumulator memory (acc_unit).
//   slave  : the controller's view (acc_rmw_ctrl)
//   master : the surrounding logic's view (array columns, consumer, memory)
// ----------------------------------------------------------------------------
interface acc_rmw_ctrl_if #(
  parameter int DATA_WIDTH = 32,
  parameter int PSUM_WIDTH = 16,
  parameter int ADDR_WIDTH = 12
);
  // partial-sum input stream
  logic                  in_valid;
  logic                  in_ready;
  logic [ADDR_WIDTH-1:0] in_addr;
  logic [PSUM_WIDTH-1:0] in_data;
  logic                  in_first;
  // drain command
  logic                  drain_start;
  logic [ADDR_WIDTH-1:0] drain_base;
  logic [ADDR_WIDTH:0]   drain_count;
  logic                  drain_clear;
  // drain output stream
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_last;
  // status
  logic                  busy;
  logic                  ovf_sticky;
  // accumulator memory ports
  logic                  mem_read_req;
  logic [ADDR_WIDTH-1:0] mem_read_addr;
  logic [DATA_WIDTH-1:0] mem_read_data;
  logic                  mem_write_req;
  logic [ADDR_WIDTH-1:0] mem_write_addr;
  logic [DATA_WIDTH-1:0] mem_write_data;

  modport slave (
    input  in_valid, in_addr, in_data, in_first,
    input  drain_start, drain_base, drain_count, drain_clear,
    input  out_ready, mem_read_data,
    output in_ready, out_valid, out_data, out_last, busy, ovf_sticky,
    output mem_read_req, mem_read_addr, mem_write_req, mem_write_addr, mem_write_data
  );

  modport master (
    output in_valid, in_addr, in_data, in_first,
    output drain_start, drain_base, drain_count, drain_clear,
    output out_ready, mem_read_data,
    input  in_ready, out_valid, out_data, out_last, busy, ovf_sticky,
    input  mem_read_req, mem_read_addr, mem_write_req, mem_write_addr, mem_write_data
  );
endinterface

// File: rtl/acc_rmw_ctrl.sv
// ----------------------------------------------------------------------------
// acc_rmw_ctrl
// Read-modify-write front end for the accumulator memory. Signed partial sums
// are added (saturating) to the stored word at their address, or overwrite it
// on a first pass, at one element per cycle. A drain command streams a
// contiguous (wrapping) address range out over valid/ready, optionally zeroing
// each drained word.
// Ports:
//   clk    : clock, all state updates on posedge
//   reset  : asynchronous, active-low reset
//   bus    : acc_rmw_ctrl_if.slave (input stream, drain command/stream,
//            busy/ovf_sticky status, acc_unit read/write ports)
// Memory read data is valid the cycle after mem_read_req.
// ----------------------------------------------------------------------------
module acc_rmw_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int PSUM_WIDTH = 16,
  parameter int ADDR_WIDTH = 12
) (
  input  logic            clk,
  input  logic            reset,
  acc_rmw_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRAIN_WAIT,
    S_DRAIN_RD,
    S_DRAIN_OUT
  } state_t;

  localparam logic [DATA_WIDTH-1:0] SAT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] SAT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic [ADDR_WIDTH:0]   ONE     = (ADDR_WIDTH+1)'(1);

  state_t                r_state;
  // stage 1: element whose read was issued last cycle, written this cycle
  logic                  r_s1_valid;
  logic                  r_s1_first;
  logic [ADDR_WIDTH-1:0] r_s1_addr;
  logic [PSUM_WIDTH-1:0] r_s1_data;
  // copy of the write issued in the previous cycle
  logic                  r_fwd_valid;
  logic [ADDR_WIDTH-1:0] r_fwd_addr;
  logic [DATA_WIDTH-1:0] r_fwd_data;
  // drain context
  logic [ADDR_WIDTH-1:0] r_base;
  logic [ADDR_WIDTH:0]   r_count;
  logic [ADDR_WIDTH:0]   r_idx;
  logic                  r_clear;
  logic                  r_out_fresh;   // first DRAIN_OUT cycle: read data is live
  logic [DATA_WIDTH-1:0] r_out_data;
  logic                  r_ovf;

  logic                         w_idle;
  logic                         w_accept;
  logic                         w_start_ok;
  logic                         w_last;
  logic                         w_clr_wr;
  logic [ADDR_WIDTH-1:0]        w_drain_addr;
  logic signed [DATA_WIDTH-1:0] w_psum_ext;
  logic [DATA_WIDTH-1:0]        w_old;
  logic [DATA_WIDTH:0]          w_sum;
  logic                         w_clamp;
  logic [DATA_WIDTH-1:0]        w_sat;
  logic [DATA_WIDTH-1:0]        w_acc_wdata;

  assign w_idle       = (r_state == S_IDLE);
  assign w_accept     = bus.in_valid & bus.in_ready;
  assign w_start_ok   = w_idle & bus.drain_start & (bus.drain_count != '0);
  assign w_last       = (r_idx == r_count - ONE);
  // ADDR_WIDTH-bit add wraps past the top of memory back to 0
  assign w_drain_addr = r_base + r_idx[ADDR_WIDTH-1:0];
  assign w_clr_wr     = (r_state == S_DRAIN_OUT) & r_out_fresh & r_clear;

  // Size cast of a signed operand sign-extends the partial sum.
  assign w_psum_ext   = DATA_WIDTH'($signed(r_s1_data));
  // A write issued last cycle may not be visible in the memory read yet.
  assign w_old        = (r_fwd_valid && (r_fwd_addr == r_s1_addr)) ? r_fwd_data
                                                                   : bus.mem_read_data;
  assign w_sum        = {w_old[DATA_WIDTH-1], w_old} + {w_psum_ext[DATA_WIDTH-1], w_psum_ext};
  // Top two bits disagree exactly when the sum left the DATA_WIDTH range.
  assign w_clamp      = w_sum[DATA_WIDTH] ^ w_sum[DATA_WIDTH-1];
  assign w_sat        = w_clamp ? (w_sum[DATA_WIDTH] ? SAT_MIN : SAT_MAX) : w_sum[DATA_WIDTH-1:0];
  assign w_acc_wdata  = r_s1_first ? w_psum_ext : w_sat;

  // in_ready is gated by the reset input so it reads 0 while reset is held.
  assign bus.in_ready       = reset & w_idle & ~bus.drain_start;
  assign bus.mem_read_req   = w_accept | (r_state == S_DRAIN_RD);
  assign bus.mem_read_addr  = w_accept                 ? bus.in_addr  :
                              (r_state == S_DRAIN_RD)  ? w_drain_addr : '0;
  // Stage-1 writes and drain-clear writes never overlap: no input is accepted
  // outside IDLE and the drain waits for stage 1 to empty.
  assign bus.mem_write_req  = r_s1_valid | w_clr_wr;
  assign bus.mem_write_addr = r_s1_valid ? r_s1_addr :
                              w_clr_wr   ? w_drain_addr : '0;
  assign bus.mem_write_data = r_s1_valid ? w_acc_wdata : '0;

  assign bus.out_valid  = (r_state == S_DRAIN_OUT);
  // In the first output cycle the word comes straight from the memory's
  // output register; afterwards from the held copy.
  assign bus.out_data   = !bus.out_valid ? '0 :
                          r_out_fresh    ? bus.mem_read_data : r_out_data;
  assign bus.out_last   = bus.out_valid & w_last;
  assign bus.busy       = ~w_idle | r_s1_valid;
  assign bus.ovf_sticky = r_ovf;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_s1_valid  <= 1'b0;
      r_s1_first  <= 1'b0;
      r_s1_addr   <= '0;
      r_s1_data   <= '0;
      r_fwd_valid <= 1'b0;
      r_fwd_addr  <= '0;
      r_fwd_data  <= '0;
      r_base      <= '0;
      r_count     <= '0;
      r_idx       <= '0;
      r_clear     <= 1'b0;
      r_out_fresh <= 1'b0;
      r_out_data  <= '0;
      r_ovf       <= 1'b0;
    end else begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_s1_addr  <= bus.in_addr;
        r_s1_data  <= bus.in_data;
        r_s1_first <= bus.in_first;
      end

      r_fwd_valid <= bus.mem_write_req;
      r_fwd_addr  <= bus.mem_write_addr;
      r_fwd_data  <= bus.mem_write_data;

      // A clamp on a write still in flight at drain start belongs to the
      // drained data, so setting takes priority over clearing.
      if (w_start_ok) r_ovf <= 1'b0;
      if (r_s1_valid && !r_s1_first && w_clamp) r_ovf <= 1'b1;

      r_out_fresh <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_start_ok) begin
            r_base  <= bus.drain_base;
            r_count <= bus.drain_count;
            r_clear <= bus.drain_clear;
            r_idx   <= '0;
            r_state <= S_DRAIN_WAIT;
          end
        end
        S_DRAIN_WAIT: begin
          if (!r_s1_valid) r_state <= S_DRAIN_RD;
        end
        S_DRAIN_RD: begin
          r_out_fresh <= 1'b1;
          r_state     <= S_DRAIN_OUT;
        end
        S_DRAIN_OUT: begin
          if (r_out_fresh) r_out_data <= bus.mem_read_data;
          if (bus.out_ready) begin
            if (w_last) begin
              r_state <= S_IDLE;
            end else begin
              r_idx   <= r_idx + ONE;
              r_state <= S_DRAIN_RD;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_acc_rmw_ctrl.sv
// ----------------------------------------------------------------------------
// tb_acc_rmw_ctrl
// Directed bench for acc_rmw_ctrl with a behavioural accumulator memory
// (registered read, write on posedge). Drained words are checked by a
// scoreboard: expected words are queued when a drain is issued and a monitor
// pops and compares on every out_valid & out_ready handshake.
// ----------------------------------------------------------------------------
module tb_acc_rmw_ctrl;
  localparam int DW = 32;
  localparam int PW = 16;
  localparam int AW = 12;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  acc_rmw_ctrl_if #(.DATA_WIDTH(DW), .PSUM_WIDTH(PW), .ADDR_WIDTH(AW)) bus ();

  acc_rmw_ctrl #(.DATA_WIDTH(DW), .PSUM_WIDTH(PW), .ADDR_WIDTH(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- memory model ----------------
  logic [DW-1:0] mem [1<<AW];
  logic          pk_en = 1'b0;
  logic [AW-1:0] pk_addr = '0;
  logic [DW-1:0] pk_data = '0;
  int            wr_count = 0;

  always @(posedge clk) begin
    if (bus.mem_read_req) bus.mem_read_data <= mem[bus.mem_read_addr];
    if (bus.mem_write_req) begin
      mem[bus.mem_write_addr] <= bus.mem_write_data;
      wr_count <= wr_count + 1;
    end
    if (pk_en) mem[pk_addr] <= pk_data;
  end

  // ---------------- scoreboard / monitor ----------------
  typedef struct packed {
    logic          last;
    logic [DW-1:0] data;
  } exp_t;

  exp_t sb_q[$];
  bit   mon_hold = 1'b0;
  exp_t mon_held;

  always @(negedge clk) begin
    exp_t cur;
    exp_t e;
    cur = '{last: bus.out_last, data: bus.out_data};
    if (bus.out_valid && mon_hold)
      check("drain_stall_stable", cur, mon_held);
    if (bus.out_valid && bus.out_ready) begin
      if (sb_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL drain_unexpected: got word 0x%0h, expected no output", bus.out_data);
      end else begin
        e = sb_q.pop_front();
        check("drain_word", cur, e);
      end
    end
    mon_hold = bus.out_valid & ~bus.out_ready;
    mon_held = cur;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1);
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic poke(input logic [AW-1:0] a, input logic [DW-1:0] d);
    pk_addr = a;
    pk_data = d;
    pk_en   = 1'b1;
    tick();
    pk_en   = 1'b0;
  endtask

  task automatic push(input logic [AW-1:0] a, input logic [PW-1:0] d, input logic first);
    bus.in_valid = 1'b1;
    bus.in_addr  = a;
    bus.in_data  = d;
    bus.in_first = first;
  endtask

  task automatic drain_cmd(input logic [AW-1:0] base, input logic [AW:0] cnt, input logic clr);
    bus.drain_start = 1'b1;
    bus.drain_base  = base;
    bus.drain_count = cnt;
    bus.drain_clear = clr;
  endtask

  // Runs a drain to completion; ready_mode 1 stalls the consumer every third cycle.
  task automatic drain_run(input string name, input int budget, input int ready_mode);
    bit done = 1'b0;
    bit saw_rdy = 1'b0;
    for (int k = 0; k < budget; k++) begin
      bus.out_ready = (ready_mode == 1) ? (k % 3 != 0) : 1'b1;
      @(negedge clk);
      if (!bus.busy) begin
        done = 1'b1;
        break;
      end
      if (bus.in_ready) saw_rdy = 1'b1;
      tick();
    end
    check({name, "_done"}, done, 1);
    check({name, "_in_ready_low"}, saw_rdy, 0);
    bus.out_ready = 1'b0;
    tick();
  endtask

  // ---------------- directed tests ----------------
  initial begin
    int w0;
    bit rdy_all;
    bit seen;

    bus.in_valid = 1'b0; bus.in_addr = '0; bus.in_data = '0; bus.in_first = 1'b0;
    bus.drain_start = 1'b0; bus.drain_base = '0; bus.drain_count = '0; bus.drain_clear = 1'b0;
    bus.out_ready = 1'b0;

    // reset state, with an offered input that must not be taken
    repeat (3) @(posedge clk);
    #1;
    bus.in_valid = 1'b1;
    @(negedge clk);
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_read_req", bus.mem_read_req, 0);
    check("rst_write_req", bus.mem_write_req, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_ovf", bus.ovf_sticky, 0);
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    tick();
    @(negedge clk);
    check("idle_in_ready", bus.in_ready, 1);
    tick();

    // 1: first-pass overwrite then accumulate, back to back
    poke(12'd5, 32'h0000_1234);
    w0 = wr_count;
    push(12'd5, 16'd7, 1'b1);
    @(negedge clk);
    check("t1_rdy_a", bus.in_ready, 1);
    check("t1_rd_addr", {bus.mem_read_req, bus.mem_read_addr}, {1'b1, 12'd5});
    tick();
    push(12'd5, 16'hFFFD, 1'b0);
    @(negedge clk);
    check("t1_rdy_b", bus.in_ready, 1);
    check("t1_wr_a", {bus.mem_write_req, bus.mem_write_data}, {1'b1, 32'd7});
    tick();
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("t1_wr_b", {bus.mem_write_req, bus.mem_write_data}, {1'b1, 32'd4});
    tick(); tick();
    check("t1_write_count", wr_count - w0, 2);
    check("t1_mem5", mem[5], 32'd4);

    // 2: eight back-to-back increments of one address
    poke(12'd9, 32'd0);
    rdy_all = 1'b1;
    for (int i = 0; i < 8; i++) begin
      push(12'd9, 16'd1, 1'b0);
      @(negedge clk);
      if (!bus.in_ready) rdy_all = 1'b0;
      tick();
    end
    bus.in_valid = 1'b0;
    tick(); tick();
    check("t2_ready_held", rdy_all, 1);
    check("t2_mem9", mem[9], 32'd8);

    // 3a: positive saturation
    poke(12'd3, 32'h7FFF_FFF0);
    check("t3_ovf_before", bus.ovf_sticky, 0);
    push(12'd3, 16'h7FFF, 1'b0);
    tick();
    bus.in_valid = 1'b0;
    tick(); tick();
    check("t3_mem3_pos_clamp", mem[3], 32'h7FFF_FFFF);
    check("t3_ovf_pos", bus.ovf_sticky, 1);

    // drain_start with count 0 is ignored and leaves ovf_sticky alone
    drain_cmd(12'd0, 13'd0, 1'b0);
    @(negedge clk);
    check("cnt0_in_ready_masked", bus.in_ready, 0);
    tick();
    bus.drain_start = 1'b0;
    @(negedge clk);
    check("cnt0_busy", bus.busy, 0);
    check("cnt0_ovf_kept", bus.ovf_sticky, 1);
    tick();

    // 4: wrapping drain with clear and a stalling consumer
    poke(12'hFFE, 32'd11);
    poke(12'hFFF, 32'd22);
    poke(12'h000, 32'd33);
    poke(12'h001, 32'd44);
    sb_q.push_back('{last: 1'b0, data: 32'd11});
    sb_q.push_back('{last: 1'b0, data: 32'd22});
    sb_q.push_back('{last: 1'b0, data: 32'd33});
    sb_q.push_back('{last: 1'b1, data: 32'd44});
    drain_cmd(12'hFFE, 13'd4, 1'b1);
    tick();
    bus.drain_start = 1'b0;
    drain_run("t4", 200, 1);
    check("t4_sb_empty", sb_q.size(), 0);
    check("t4_mem_ffe", mem[12'hFFE], 32'd0);
    check("t4_mem_fff", mem[12'hFFF], 32'd0);
    check("t4_mem_000", mem[12'h000], 32'd0);
    check("t4_mem_001", mem[12'h001], 32'd0);
    check("t4_busy", bus.busy, 0);
    check("t4_ovf_cleared", bus.ovf_sticky, 0);

    // 3b: negative saturation
    poke(12'd4, 32'h8000_0010);
    push(12'd4, 16'h8000, 1'b0);
    tick();
    bus.in_valid = 1'b0;
    tick(); tick();
    check("t3_mem4_neg_clamp", mem[4], 32'h8000_0000);
    check("t3_ovf_neg", bus.ovf_sticky, 1);

    // 6a: reset while a read-modify-write is in flight
    poke(12'd30, 32'd50);
    push(12'd30, 16'd1, 1'b0);
    tick();
    bus.in_valid = 1'b0;
    check("t6a_wr_pending", bus.mem_write_req, 1);
    reset = 1'b0;
    #1;
    check("t6a_wr_dropped", bus.mem_write_req, 0);
    check("t6a_busy", bus.busy, 0);
    check("t6a_ovf_reset", bus.ovf_sticky, 0);
    w0 = wr_count;
    repeat (3) tick();
    check("t6a_no_writes", wr_count - w0, 0);
    check("t6a_mem30", mem[30], 32'd50);
    reset = 1'b1;
    tick();

    // 5: drain issued while stage 1 still holds an element
    poke(12'd20, 32'd100);
    push(12'd20, 16'd5, 1'b0);
    tick();
    bus.in_valid = 1'b0;
    drain_cmd(12'd20, 13'd1, 1'b0);
    sb_q.push_back('{last: 1'b1, data: 32'd105});
    @(negedge clk);
    check("t5_in_ready_masked", bus.in_ready, 0);
    check("t5_pending_write", {bus.mem_write_req, bus.mem_write_data}, {1'b1, 32'd105});
    tick();
    bus.drain_start = 1'b0;
    drain_run("t5", 50, 0);
    check("t5_sb_empty", sb_q.size(), 0);
    check("t5_mem20", mem[20], 32'd105);

    // 6b: reset while a drained word is waiting for the consumer
    poke(12'd40, 32'd1);
    poke(12'd41, 32'd2);
    poke(12'd42, 32'd3);
    bus.out_ready = 1'b0;
    drain_cmd(12'd40, 13'd3, 1'b1);
    tick();
    bus.drain_start = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        seen = 1'b1;
        break;
      end
    end
    check("t6b_out_valid_seen", seen, 1);
    reset = 1'b0;
    #1;
    check("t6b_out_valid_dropped", bus.out_valid, 0);
    check("t6b_wr_dropped", bus.mem_write_req, 0);
    check("t6b_busy", bus.busy, 0);
    w0 = wr_count;
    repeat (3) tick();
    check("t6b_no_writes", wr_count - w0, 0);
    check("t6b_mem40", mem[40], 32'd1);
    check("t6b_mem41", mem[41], 32'd2);
    check("t6b_mem42", mem[42], 32'd3);
    reset = 1'b1;
    tick();
    @(negedge clk);
    check("t6b_idle_in_ready", bus.in_ready, 1);
    check("t6b_idle_busy", bus.busy, 0);
    check("final_sb_empty", sb_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
